// File: rtl/idct_pkg.sv
// Shared constants and FSM encoding for the 8-point column IDCT.
// Scaled basis matrix W[u][k], rounding term and output shift.
package idct_pkg;

  localparam int RND   = 64;
  localparam int SHIFT = 7;

  localparam int W [8][8] = '{
    '{ 45,  45,  45,  45,  45,  45,  45,  45},
    '{ 64,  56,  36,  12, -12, -36, -56, -64},
    '{ 60,  24, -24, -60, -60, -24,  24,  60},
    '{ 56, -12, -64, -36,  36,  64,  12, -56},
    '{ 45, -45, -45,  45,  45, -45, -45,  45},
    '{ 36, -64,  12,  56, -56, -12,  64, -36},
    '{ 24, -60,  60, -24, -24,  60, -60,  24},
    '{ 12, -36,  56, -64,  64, -56,  36, -12}
  };

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    OUT
  } state_t;

endpackage

// File: rtl/idct_dot8.sv
// One 8-term IDCT dot product for output k, with optional product masking.
// IDCT_SAT_EN selects saturation of the rounded result; default wraps.
import idct_pkg::*;

module idct_dot8 #(
  parameter int SIZE        = 10,
  parameter int SIZE_OUT    = 8,
  parameter int APPROX_BITS = 6
) (
  input  logic [7:0][SIZE-1:0]        col,
  input  logic                        approx,
  input  logic [2:0]                  k,
  output logic signed [SIZE_OUT-1:0]  y
);

  localparam int ACC = SIZE + 12;
  localparam logic [ACC-1:0] MASK =
    ~((ACC'(1) << APPROX_BITS) - ACC'(1));

  logic signed [ACC-1:0] cx;
  logic signed [ACC-1:0] wx;
  logic signed [ACC-1:0] prod;
  logic signed [ACC-1:0] acc;
  logic signed [ACC-1:0] sum;
  logic signed [ACC-1:0] sh;

  always_comb begin
    acc  = '0;
    cx   = '0;
    wx   = '0;
    prod = '0;
    for (int u = 0; u < 8; u++) begin
      cx   = {{12{col[u][SIZE-1]}}, col[u]};
      wx   = ACC'(W[u][k]);
      prod = cx * wx;
      if (approx)
        prod = prod & MASK;
      acc = acc + prod;
    end
    sum = acc + ACC'(RND);
    sh  = sum >>> SHIFT;
  end

`ifdef IDCT_SAT_EN
  localparam logic signed [ACC-1:0] MAXV =
    ACC'((1 << (SIZE_OUT - 1)) - 1);
  localparam logic signed [ACC-1:0] MINV = ~MAXV;

  always_comb begin
    if (sh > MAXV)
      y = MAXV[SIZE_OUT-1:0];
    else if (sh < MINV)
      y = MINV[SIZE_OUT-1:0];
    else
      y = sh[SIZE_OUT-1:0];
  end
`else
  logic unused_hi;
  assign unused_hi = ^sh[ACC-1:SIZE_OUT];
  assign y = sh[SIZE_OUT-1:0];
`endif

endmodule

// File: rtl/idct_col_seq.sv
// Column IDCT: accepts 8 coefficients, streams 8 samples one per handshake.
// Build with IDCT_SAT_EN to saturate outputs instead of wrapping.
import idct_pkg::*;

module idct_col_seq #(
  parameter int SIZE        = 10,
  parameter int SIZE_OUT    = 8,
  parameter int APPROX_BITS = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0][SIZE-1:0]       coeff_in,
  input  logic                       approx_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [SIZE_OUT-1:0] data_out,
  output logic [2:0]                 out_idx,
  output logic                       out_last
);

  state_t                      state;
  logic [7:0][SIZE-1:0]        col_q;
  logic                        apx_q;
  logic [2:0]                  k_sel;
  logic signed [SIZE_OUT-1:0]  x_k;

  assign in_ready = (state == IDLE);
  // CALC produces k=0; OUT pre-computes the sample after the one shown
  assign k_sel = (state == OUT) ? out_idx + 3'd1 : 3'd0;

  idct_dot8 #(
    .SIZE        (SIZE),
    .SIZE_OUT    (SIZE_OUT),
    .APPROX_BITS (APPROX_BITS)
  ) u_dot (
    .col    (col_q),
    .approx (apx_q),
    .k      (k_sel),
    .y      (x_k)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      col_q     <= '0;
      apx_q     <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            col_q <= coeff_in;
            apx_q <= approx_en;
            state <= CALC;
          end
        end
        CALC: begin
          data_out  <= x_k;
          out_idx   <= 3'd0;
          out_valid <= 1'b1;
          out_last  <= 1'b0;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            if (out_idx == 3'd7) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= IDLE;
            end else begin
              data_out <= x_k;
              out_idx  <= out_idx + 3'd1;
              out_last <= (out_idx == 3'd6);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_idct_col_seq.sv
// Scoreboard bench for idct_col_seq: directed columns, monitor-side compare.
// Expected samples are hand-computed; IDCT_SAT_EN selects the saturating set.
module tb_idct_col_seq;

  localparam int SIZE = 10;
  localparam int SO   = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [7:0][SIZE-1:0] coeff_in = '0;
  logic                 approx_en = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [SO-1:0] data_out;
  logic [2:0]           out_idx;
  logic                 out_last;

  typedef struct {
    int data;
    int idx;
    bit last;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  idct_col_seq #(
    .SIZE        (SIZE),
    .SIZE_OUT    (SO),
    .APPROX_BITS (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .coeff_in  (coeff_in),
    .approx_en (approx_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  // monitor: pops one expectation per handshake the DUT will take
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual idx %0d required none", out_idx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("beat_data", int'(data_out), e.data);
        chk("beat_idx", int'(out_idx), e.idx);
        chk("beat_last", int'(out_last), int'(e.last));
      end
    end
  end

  task automatic send(input int x[8], input bit apx, input int ev[8]);
    int n;
    for (n = 0; n < 200 && !in_ready; n++) @(negedge clk);
    if (!in_ready) begin
      chk("in_ready_timeout", int'(in_ready), 1);
      return;
    end
    for (int u = 0; u < 8; u++) coeff_in[u] = x[u][SIZE-1:0];
    approx_en = apx;
    in_valid  = 1'b1;
    for (int k = 0; k < 8; k++) sb.push_back('{ev[k], k, (k == 7)});
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    approx_en = 1'b0;
    coeff_in  = '1;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 200 && sb.size() != 0; n++) @(negedge clk);
    chk("drain_timeout", sb.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int xv[8];
    int ev[8];
    int found;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_out_last", int'(out_last), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", int'(in_ready), 1);

    // DC column with latency / burst timing
    xv = '{128, 0, 0, 0, 0, 0, 0, 0};
    ev = '{45, 45, 45, 45, 45, 45, 45, 45};
    send(xv, 1'b0, ev);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk("t1_valid_timing", int'(out_valid), (i >= 2 && i <= 9) ? 1 : 0);
      if (i >= 2 && i <= 9) chk("t1_in_ready", int'(in_ready), 0);
    end
    drain();

    xv = '{0, 128, 0, 0, 0, 0, 0, 0};
    ev = '{64, 56, 36, 12, -12, -36, -56, -64};
    send(xv, 1'b0, ev);
    drain();

    xv = '{511, 0, 511, 0, 0, 0, 0, 0};
`ifdef IDCT_SAT_EN
    ev = '{127, 127, 84, -60, -60, 84, 127, 127};
`else
    ev = '{-93, 19, 84, -60, -60, 84, 19, -93};
`endif
    send(xv, 1'b0, ev);
    drain();

    xv = '{1, 0, 1, 0, 0, 0, 0, 0};
    ev = '{1, 1, 0, 0, 0, 0, 1, 1};
    send(xv, 1'b0, ev);
    drain();
    ev = '{0, 0, 0, 0, 0, 0, 0, 0};
    send(xv, 1'b1, ev);
    drain();

    xv = '{0, 0, 0, -1, 0, 0, 0, 0};
    ev = '{0, 0, 1, 0, 0, 0, 0, 0};
    send(xv, 1'b1, ev);
    drain();

    // backpressure at k=2 with a competing column offered
    xv = '{0, 128, 0, 0, 0, 0, 0, 0};
    ev = '{64, 56, 36, 12, -12, -36, -56, -64};
    send(xv, 1'b0, ev);
    found = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (out_valid && out_idx == 3'd1) begin
        found = 1;
        break;
      end
    end
    chk("stall_reach_k1", found, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    coeff_in  = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_data", int'(data_out), 36);
      chk("stall_idx", int'(out_idx), 2);
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    drain();
    repeat (12) @(negedge clk);
    chk("stall_no_accept", int'(out_valid), 0);

    // reset after the k=3 handshake discards the rest of the column
    xv = '{128, 0, 0, 0, 0, 0, 0, 0};
    ev = '{45, 45, 45, 45, 45, 45, 45, 45};
    send(xv, 1'b0, ev);
    found = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_idx == 3'd3) begin
        found = 1;
        break;
      end
    end
    chk("rst_reach_k3", found, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_idx", int'(out_idx), 0);
    chk("midrst_data_out", int'(data_out), 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", int'(in_ready), 1);
    xv = '{0, 128, 0, 0, 0, 0, 0, 0};
    ev = '{64, 56, 36, 12, -12, -36, -56, -64};
    send(xv, 1'b0, ev);
    drain();

    repeat (15) @(negedge clk);
    chk("final_queue_empty", sb.size(), 0);
    chk("final_out_valid", int'(out_valid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
